mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the shared memory request port. It accepts level-signalled read/write requests from the arbitrating request handler and reports `mem_busy` while a transfer is outstanding. Each accepted request runs as one Wishbone classic-cycle master transaction toward SRAM/peripherals. Read data is returned on `data_from_mem`, and a watchdog aborts transactions that are never acknowledged.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `ack_i` before aborting; legal range 1..65535.
- `clk` input 1: system clock.
- `nRst` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request (level).
- `mem_write` input 1: write request (level); takes priority over `mem_read` when both are high.
- `adr_to_mem` input 32: request byte address, passed unmodified.
- `data_to_mem` input 32: write data.
- `sel_to_mem` input 4: byte lane enables.
- `mem_busy` output 1: transfer outstanding (registered).
- `data_from_mem` output 32: last completed read data (registered, held).
- `timeout_err` output 1: sticky flag; set when any transaction times out.
- `cyc_o`, `stb_o`, `we_o` output 1 each: Wishbone master controls.
- `adr_o` output 32, `dat_o` output 32, `sel_o` output 4: Wishbone address, write data, byte select.
- `dat_i` input 32, `ack_i` input 1: Wishbone read data and acknowledge.

## Operation
- FSM states: IDLE, BUS (Wishbone cycle active), plus a one-cycle ABORT.
- IDLE:
  - If `mem_write | mem_read` is sampled at a clock edge, latch the address, data and select, and set `we = mem_write`.
  - Clear the timeout counter and go to BUS.
  - If there is no request, stay in IDLE.
- BUS:
  - `cyc_o = stb_o = 1`; `we_o`, `adr_o`, `dat_o`, `sel_o` are driven from the latched values and stay stable for the whole cycle.
  - Input request changes while in BUS are ignored.
- BUS, `ack_i` high at an edge:
  - For reads, capture `dat_i` into `data_from_mem`. Writes leave `data_from_mem` unchanged.
  - Go to IDLE.
- BUS, no ack:
  - Increment the counter.
  - When the counter equals `TIMEOUT_CYCLES - 1` and there is still no ack, go to ABORT.
- ABORT:
  - `cyc_o = stb_o = 0`, `mem_busy = 1`, `data_from_mem` is loaded with 0 for reads, and `timeout_err` is set.
  - Next state is IDLE.
- `mem_busy = 1` exactly in BUS and ABORT.
- `sel_to_mem = 0` is still issued as a transaction; no filtering is done.
- Outputs are 0 in IDLE: `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o`, `sel_o`.

## Timing
- Reset values:
  - state IDLE, `mem_busy` 0, `data_from_mem` 0, `timeout_err` 0.
  - All Wishbone outputs 0, counter 0.
- Asserting `nRst` mid-transaction drops `cyc_o`/`stb_o` asynchronously; the transaction is lost and no error is flagged.
- Request sampled at edge E0: `mem_busy` and `cyc_o`/`stb_o` go high after E0.
- `ack_i` sampled at edge Ek (k≥1): after Ek, `mem_busy` is 0 and read data is valid. Minimum busy width is 1 cycle.
- Back-to-back transfers: a request present at the same edge where BUS exits on ack is not accepted. It is sampled at the next edge (one IDLE cycle minimum between transactions).
- The busy falling edge marks completion and is a single registered transition.
- `data_from_mem` holds its value until the next completed read or abort.
- Timeout: with no ack, `mem_busy` stays high for `TIMEOUT_CYCLES + 1` cycles, the last of which is ABORT.
- An `ack_i` arriving in ABORT or IDLE is ignored.

## Structure
- Shared package `mem_resp_pkg`: state enum (IDLE=2'd0, BUS=2'd1, ABORT=2'd2) and `DEFAULT_TIMEOUT` = 255.
- One sub-module, `mem_timeout_counter`: 16-bit counter with clear, enable, and an `expired` compare against `TIMEOUT_CYCLES - 1`.
- The FSM, latches and Wishbone drive stay in `mem_responder`.

## Test plan
- Reset: hold `nRst`=0 with `mem_read`=1 → all outputs 0. After release, the request is sampled at the first edge and `mem_busy`=1 on the next cycle.
- Read, ack delay 3: read `adr_to_mem`=0x0000_0100, `dat_i`=0xCAFE_F00D → `cyc_o`/`stb_o` high 3 cycles, `mem_busy` high 3 cycles, `data_from_mem`=0xCAFE_F00D afterward, `we_o`=0 throughout.
- Write with `sel_to_mem`=4'b0011, `data_to_mem`=0x1234_5678, ack delay 1 → `we_o`=1, `sel_o`=0011, `dat_o`=0x1234_5678 for 1 cycle; `data_from_mem` unchanged.
- Simultaneous read+write, address changed mid-BUS → `we_o`=1, and `adr_o` holds the originally latched address until ack.
- Timeout, `TIMEOUT_CYCLES`=4, no ack → busy 5 cycles, `cyc_o` drops after 4, `timeout_err`=1, `data_from_mem`=0. A late `ack_i` is ignored. A following read with ack succeeds while `timeout_err` stays 1.
- Reset mid-BUS → `cyc_o`/`stb_o` fall without a clock edge; `timeout_err` stays 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the memory responder
// Purpose: state encoding for the responder FSM and the default watchdog limit.
// Ports: none (package).
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - watchdog cycle counter for an outstanding bus cycle
// Purpose: counts unacknowledged bus cycles and flags the last allowed one.
// Ports:
//   clk, nRst  : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : advance the count by one
//   expired    : count has reached TIMEOUT_CYCLES - 1
module mem_timeout_counter
  import mem_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request port to Wishbone classic master bridge with watchdog
// Purpose: accepts level read/write requests, runs one Wishbone classic cycle per
// request, returns read data, and aborts cycles that are never acknowledged.
// Ports:
//   clk, nRst                         : clock, asynchronous active-low reset
//   mem_read, mem_write               : level requests (write wins when both high)
//   adr_to_mem, data_to_mem, sel_to_mem : request address, write data, byte lanes
//   mem_busy                          : transfer outstanding
//   data_from_mem                     : last completed read data (0 after a read timeout)
//   timeout_err                       : sticky watchdog flag
//   cyc_o, stb_o, we_o, adr_o, dat_o, sel_o : Wishbone master outputs
//   dat_i, ack_i                      : Wishbone read data and acknowledge
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic [3:0]  sel_to_mem,
  output logic        mem_busy,
  output logic [31:0] data_from_mem,
  output logic        timeout_err,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  state_t state;
  logic   expired;

  // Counter is held at zero outside BUS, so every cycle starts counting from 0.
  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .nRst    (nRst),
    .clr     (state != BUS),
    .en      (state == BUS && !ack_i),
    .expired (expired)
  );

  // The Wishbone output registers double as the request latches: they are
  // loaded on acceptance and held untouched for the whole cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      mem_busy      <= 1'b0;
      data_from_mem <= 32'd0;
      timeout_err   <= 1'b0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= 32'd0;
      dat_o         <= 32'd0;
      sel_o         <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            state    <= BUS;
            mem_busy <= 1'b1;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            we_o     <= mem_write;
            adr_o    <= adr_to_mem;
            dat_o    <= data_to_mem;
            sel_o    <= sel_to_mem;
          end
        end
        BUS: begin
          // An ack on the last allowed cycle still completes normally.
          if (ack_i || expired) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            adr_o <= 32'd0;
            dat_o <= 32'd0;
            sel_o <= 4'd0;
            if (ack_i) begin
              state    <= IDLE;
              mem_busy <= 1'b0;
              if (!we_o) data_from_mem <= dat_i;
            end else begin
              state       <= ABORT;
              timeout_err <= 1'b1;
              if (!we_o) data_from_mem <= 32'd0;
            end
          end
        end
        ABORT: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
          cyc_o    <= 1'b0;
          stb_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  localparam int T = 4;

  logic        clk;
  logic        nRst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic [3:0]  sel_to_mem;
  logic        mem_busy;
  logic [31:0] data_from_mem;
  logic        timeout_err;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;

  int n_checks = 0;
  int n_errors = 0;

  // reference state: what the responder should be reporting between transfers
  logic [31:0] m_data;
  logic        m_err;

  mem_responder #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .adr_to_mem    (adr_to_mem),
    .data_to_mem   (data_to_mem),
    .sel_to_mem    (sel_to_mem),
    .mem_busy      (mem_busy),
    .data_from_mem (data_from_mem),
    .timeout_err   (timeout_err),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .we_o          (we_o),
    .adr_o         (adr_o),
    .dat_o         (dat_o),
    .sel_o         (sel_o),
    .dat_i         (dat_i),
    .ack_i         (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] wb_vec();
    return {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o};
  endfunction

  // One request. ack_at = bus cycle (1-based) on which ack is driven; values
  // beyond T give a timeout (T+1 lands the ack in the abort cycle).
  // hold keeps the request asserted to probe the mandatory idle gap.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input logic [31:0] rdat, input int ack_at, input logic hold);
    logic        exp_we;
    int          exp_bus;
    int          exp_busy;
    int          busy_cnt;
    logic        timed_out;
    exp_we    = wr;
    timed_out = !(ack_at >= 1 && ack_at <= T);
    exp_bus   = timed_out ? T : ack_at;
    exp_busy  = timed_out ? T + 1 : ack_at;
    busy_cnt  = 0;
    @(negedge clk);
    mem_write = wr; mem_read = rd;
    adr_to_mem = adr; data_to_mem = wdat; sel_to_mem = sel; dat_i = rdat;
    @(negedge clk);
    // changes during the bus cycle must be ignored
    if (!hold) begin
      mem_write = 1'b0; mem_read = 1'b0;
    end
    adr_to_mem = $urandom; data_to_mem = $urandom; sel_to_mem = 4'($urandom);
    for (int c = 1; c <= 40 && mem_busy; c++) begin
      busy_cnt++;
      check("cyc_stb", {cyc_o, stb_o}, (c <= exp_bus) ? 2'b11 : 2'b00);
      if (c <= exp_bus)
        check("wb_drive", wb_vec(), {2'b11, exp_we, adr, wdat, sel});
      ack_i = (c == ack_at);
      @(negedge clk);
      ack_i = 1'b0;
    end
    check("busy_len", busy_cnt, exp_busy);
    if (timed_out) begin
      m_err = 1'b1;
      if (!exp_we) m_data = 32'd0;
    end else if (!exp_we) begin
      m_data = rdat;
    end
    check("idle_wb", wb_vec(), 71'd0);
    check("data_from_mem", data_from_mem, m_data);
    check("timeout_err", timeout_err, m_err);
    if (hold) begin
      check("gap_busy", mem_busy, 1'b0);
      @(negedge clk);
      check("reaccept", mem_busy, 1'b1);
      mem_write = 1'b0; mem_read = 1'b0;
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      if (!exp_we) m_data = rdat;
      check("reaccept_done", mem_busy, 1'b0);
      check("reaccept_data", data_from_mem, m_data);
    end
  endtask

  initial begin
    nRst = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    adr_to_mem = 32'h0000_0040; data_to_mem = 32'd0; sel_to_mem = 4'hF;
    dat_i = 32'h5555_AAAA; ack_i = 1'b0;
    m_data = 32'd0; m_err = 1'b0;

    // reset held with a pending read
    repeat (3) @(negedge clk);
    check("rst_wb", wb_vec(), 71'd0);
    check("rst_status", {mem_busy, timeout_err, data_from_mem}, 34'd0);
    nRst = 1'b1;
    @(negedge clk);
    check("rst_first_req", mem_busy, 1'b1);
    check("rst_first_adr", adr_o, 32'h0000_0040);
    mem_read = 1'b0; ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0; m_data = 32'h5555_AAAA;
    check("rst_first_done", {mem_busy, data_from_mem}, {1'b0, m_data});

    // directed cases
    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'd0, 4'hF, 32'hCAFE_F00D, 3, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 4'b0011, 32'hDEAD_BEEF, 1, 1'b0);
    run_txn(1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_0001, 4'b1000, 32'h1111_2222, 2, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 4'b0000, 32'h3333_4444, 1, 1'b1);

    // asynchronous reset in the middle of a bus cycle
    @(negedge clk);
    mem_read = 1'b1; adr_to_mem = 32'h0000_0500;
    @(negedge clk);
    mem_read = 1'b0;
    check("midrst_busy", mem_busy, 1'b1);
    #2 nRst = 1'b0;
    #1;
    check("midrst_cyc_stb", {cyc_o, stb_o}, 2'b00);
    check("midrst_err", timeout_err, 1'b0);
    @(negedge clk);
    nRst = 1'b1;
    m_data = 32'd0; m_err = 1'b0;
    check("midrst_data", data_from_mem, m_data);

    // timeout with a late ack in the abort cycle, then a good read
    run_txn(1'b0, 1'b1, 32'h0000_0600, 32'd0, 4'hF, 32'h7777_8888, T + 1, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0000_0700, 32'd0, 4'hF, 32'h9999_0000, 2, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic wr;
      logic rd;
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      run_txn(wr, rd, $urandom, $urandom, 4'($urandom), $urandom,
              int'($urandom_range(1, T + 2)), 1'($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
